// File: rtl/gfx_pkg.sv
// Shared constants and state encoding for the gfx pixel-write path.
package gfx_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [0:0] {
        WR_IDLE  = 1'b0,
        WR_ISSUE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/gfx_pixel_axi_writer.sv
// Turns a stream of (x, y, RGB) pixels into single-beat AXI4 writes to a linear
// framebuffer, tracking outstanding responses, frame completion and bus errors.
module gfx_pixel_axi_writer
    import gfx_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 21,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int COLOR_WIDTH     = 4,
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12,
    parameter int FB_WIDTH        = 640,
    parameter int FB_HEIGHT       = 480,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        s_pix_valid,
    output logic                        s_pix_ready,
    input  logic [H_WIDTH-1:0]          s_pix_x,
    input  logic [V_WIDTH-1:0]          s_pix_y,
    input  logic [COLOR_WIDTH-1:0]      s_pix_red,
    input  logic [COLOR_WIDTH-1:0]      s_pix_grn,
    input  logic [COLOR_WIDTH-1:0]      s_pix_blu,
    input  logic                        s_pix_last,

    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,

    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,

    input  logic                        m_axi_bvalid,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_bready,

    output logic                        frame_done,
    output logic                        busy,
    output logic                        axi_error
);

    localparam int ADDR_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);

    wr_state_e                     state_q, state_d;
    logic [H_WIDTH-1:0]            x_q, x_d;
    logic [V_WIDTH-1:0]            y_q, y_d;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic [CNT_W-1:0]              outstanding_q, outstanding_d;
    logic                          pending_last_q, pending_last_d;
    logic                          axi_error_q, axi_error_d;

    logic                          pix_fire, pix_in_range;
    logic                          aw_hs, w_hs, b_hs;
    logic                          frame_done_int;
    logic [AXI_ADDR_WIDTH-1:0]     pix_index;

    // All valid/ready handshakes are masked while reset is low, so nothing can
    // complete on the reset edge even if registers still hold old state.
    assign s_pix_ready   = rst_n && (state_q == WR_IDLE)
                           && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign m_axi_awvalid = rst_n && awvalid_q;
    assign m_axi_wvalid  = rst_n && wvalid_q;
    assign m_axi_bready  = 1'b1;

    assign pix_fire     = s_pix_valid && s_pix_ready;
    assign pix_in_range = (32'(s_pix_x) < FB_WIDTH) && (32'(s_pix_y) < FB_HEIGHT);
    assign aw_hs        = m_axi_awvalid && m_axi_awready;
    assign w_hs         = m_axi_wvalid && m_axi_wready;
    assign b_hs         = rst_n && m_axi_bvalid && m_axi_bready;

    // Modular arithmetic, so computing directly in the address width truncates correctly.
    assign pix_index     = AXI_ADDR_WIDTH'(y_q) * AXI_ADDR_WIDTH'(FB_WIDTH) + AXI_ADDR_WIDTH'(x_q);
    assign m_axi_awaddr  = pix_index << ADDR_SHIFT;
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(ADDR_SHIFT);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = 1'b1;

    assign frame_done_int = pending_last_q && (state_q == WR_IDLE) && (outstanding_q == '0);
    assign frame_done     = rst_n && frame_done_int;
    assign busy           = rst_n && ((state_q != WR_IDLE) || (outstanding_q != '0));
    assign axi_error      = axi_error_q;

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        wdata_d        = wdata_q;
        awvalid_d      = awvalid_q && !aw_hs;
        wvalid_d       = wvalid_q && !w_hs;
        pending_last_d = pending_last_q && !frame_done_int;
        outstanding_d  = outstanding_q;
        axi_error_d    = axi_error_q || (b_hs && (m_axi_bresp != AXI_RESP_OKAY));

        // Out-of-range pixels are swallowed but still count towards frame end.
        if (pix_fire) begin
            x_d     = s_pix_x;
            y_d     = s_pix_y;
            wdata_d = AXI_DATA_WIDTH'({s_pix_red, s_pix_grn, s_pix_blu});
            if (s_pix_last) pending_last_d = 1'b1;
            if (pix_in_range) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = WR_ISSUE;
            end
        end

        if ((state_q == WR_ISSUE) && !awvalid_d && !wvalid_d) state_d = WR_IDLE;

        case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= WR_IDLE;
            x_q            <= '0;
            y_q            <= '0;
            wdata_q        <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            outstanding_q  <= '0;
            pending_last_q <= 1'b0;
            axi_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            wdata_q        <= wdata_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            outstanding_q  <= outstanding_d;
            pending_last_q <= pending_last_d;
            axi_error_q    <= axi_error_d;
        end
    end

endmodule

// File: tb/tb_gfx_pixel_axi_writer.sv
// Directed bench for gfx_pixel_axi_writer: hand-computed addresses/data checked
// by a handshake monitor, plus flow-control, frame-end, error and reset cases.
module tb_gfx_pixel_axi_writer;

    localparam int AW = 21;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_pix_valid;
    logic            s_pix_ready;
    logic [11:0]     s_pix_x;
    logic [11:0]     s_pix_y;
    logic [CW-1:0]   s_pix_red, s_pix_grn, s_pix_blu;
    logic            s_pix_last;
    logic            m_axi_awvalid, m_axi_awready;
    logic [AW-1:0]   m_axi_awaddr;
    logic [IW-1:0]   m_axi_awid;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_wvalid, m_axi_wready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_bvalid;
    logic [IW-1:0]   m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bready;
    logic            frame_done, busy, axi_error;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int fd_cnt   = 0;
    int aw0, w0, fd0;

    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] expd_q[$];

    gfx_pixel_axi_writer dut (
        .clk(clk), .rst_n(rst_n),
        .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
        .s_pix_x(s_pix_x), .s_pix_y(s_pix_y),
        .s_pix_red(s_pix_red), .s_pix_grn(s_pix_grn), .s_pix_blu(s_pix_blu),
        .s_pix_last(s_pix_last),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid),
        .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .frame_done(frame_done), .busy(busy), .axi_error(axi_error)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every AW/W handshake is checked against the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                check("aw_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("awaddr_sb", m_axi_awaddr, exp_q.pop_front());
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt++;
                check("w_expected", 32'(expd_q.size() != 0), 1);
                if (expd_q.size() != 0) check("wdata_sb", m_axi_wdata, expd_q.pop_front());
            end
            if (frame_done) fd_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_q.push_back(addr);
        expd_q.push_back(data);
    endtask

    // Returns 1 ns after the capturing edge.
    task automatic send_pix(input int x, input int y, input int r, input int g, input int b,
                            input logic last);
        logic hs;
        s_pix_valid = 1'b1;
        s_pix_x     = 12'(x);
        s_pix_y     = 12'(y);
        s_pix_red   = CW'(r);
        s_pix_grn   = CW'(g);
        s_pix_blu   = CW'(b);
        s_pix_last  = last;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = s_pix_ready;
            @(posedge clk);
            #1;
        end
        s_pix_valid = 1'b0;
        s_pix_last  = 1'b0;
        check("pix_accept", hs, 1);
    endtask

    task automatic send_b(input logic [1:0] resp);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp;
        tick();
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        s_pix_valid = 1'b0; s_pix_x = '0; s_pix_y = '0; s_pix_last = 1'b0;
        s_pix_red = '0; s_pix_grn = '0; s_pix_blu = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        m_axi_bvalid = 1'b0; m_axi_bid = '0; m_axi_bresp = 2'b00;

        // Reset state
        repeat (3) tick();
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_ready", s_pix_ready, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", s_pix_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_error", axi_error, 0);
        check("post_rst_bready", m_axi_bready, 1);

        // 1: single pixel, constant AXI fields
        expect_wr(21'h00A06, 16'h0A5C);
        send_pix(3, 2, 4'hA, 4'h5, 4'hC, 1'b0);
        check("t1_awvalid", m_axi_awvalid, 1);
        check("t1_wvalid", m_axi_wvalid, 1);
        check("t1_awaddr", m_axi_awaddr, 32'h0A06);
        check("t1_wdata", m_axi_wdata, 32'h0A5C);
        check("t1_awlen", m_axi_awlen, 0);
        check("t1_awsize", m_axi_awsize, 1);
        check("t1_awburst", m_axi_awburst, 2'b01);
        check("t1_awid", m_axi_awid, 0);
        check("t1_wstrb", m_axi_wstrb, 2'b11);
        check("t1_wlast", m_axi_wlast, 1);
        check("t1_ready_issue", s_pix_ready, 0);
        tick();
        check("t1_awvalid_low", m_axi_awvalid, 0);
        check("t1_wvalid_low", m_axi_wvalid, 0);
        check("t1_busy_outst", busy, 1);
        send_b(2'b00);
        check("t1_busy_done", busy, 0);

        // 2: AW backpressure, W accepted first
        aw0 = aw_cnt; w0 = w_cnt;
        m_axi_awready = 1'b0;
        expect_wr(21'h00514, 16'h0123);
        send_pix(10, 1, 1, 2, 3, 1'b0);
        tick();
        check("t2_wvalid_low", m_axi_wvalid, 0);
        for (int i = 0; i < 4; i++) begin
            check("t2_awvalid_hold", m_axi_awvalid, 1);
            check("t2_awaddr_stable", m_axi_awaddr, 32'h0514);
            check("t2_ready_low", s_pix_ready, 0);
            tick();
        end
        m_axi_awready = 1'b1;
        tick();
        check("t2_awvalid_low", m_axi_awvalid, 0);
        check("t2_ready_back", s_pix_ready, 1);
        check("t2_aw_count", aw_cnt - aw0, 1);
        check("t2_w_count", w_cnt - w0, 1);
        send_b(2'b00);

        // 3: outstanding limit
        aw0 = aw_cnt;
        for (int i = 0; i < 4; i++) expect_wr(21'h01900, 16'h0FFF);
        s_pix_valid = 1'b1; s_pix_x = 12'd0; s_pix_y = 12'd5;
        s_pix_red = 4'hF; s_pix_grn = 4'hF; s_pix_blu = 4'hF;
        repeat (12) tick();
        s_pix_valid = 1'b0;
        check("t3_aw_count", aw_cnt - aw0, 4);
        check("t3_ready_full", s_pix_ready, 0);
        check("t3_busy", busy, 1);
        send_b(2'b00);
        check("t3_ready_reopen", s_pix_ready, 1);
        repeat (3) send_b(2'b00);
        check("t3_busy_drained", busy, 0);

        // 4: 4-pixel frame on the last line, responses delayed
        fd0 = fd_cnt;
        expect_wr(21'h95FF8, 16'h0111);
        expect_wr(21'h95FFA, 16'h0222);
        expect_wr(21'h95FFC, 16'h0333);
        expect_wr(21'h95FFE, 16'h0444);
        send_pix(636, 479, 1, 1, 1, 1'b0);
        send_pix(637, 479, 2, 2, 2, 1'b0);
        send_pix(638, 479, 3, 3, 3, 1'b0);
        send_pix(639, 479, 4, 4, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_fd_wait", frame_done, 0);
        end
        for (int i = 0; i < 3; i++) begin
            send_b(2'b00);
            check("t4_fd_early", frame_done, 0);
            check("t4_busy_early", busy, 1);
        end
        send_b(2'b00);
        check("t4_frame_done", frame_done, 1);
        check("t4_busy_fall", busy, 0);
        tick();
        check("t4_fd_pulse_end", frame_done, 0);
        check("t4_fd_count", fd_cnt - fd0, 1);

        // 5: dropped pixels
        aw0 = aw_cnt; fd0 = fd_cnt;
        send_pix(0, 480, 7, 7, 7, 1'b0);
        check("t5_drop_y_fd", frame_done, 0);
        check("t5_drop_y_awvalid", m_axi_awvalid, 0);
        send_pix(640, 0, 7, 7, 7, 1'b1);
        check("t5_drop_fd", frame_done, 1);
        check("t5_drop_awvalid", m_axi_awvalid, 0);
        check("t5_drop_busy", busy, 0);
        tick();
        check("t5_fd_pulse_end", frame_done, 0);
        repeat (2) tick();
        check("t5_no_aw", aw_cnt - aw0, 0);
        check("t5_fd_count", fd_cnt - fd0, 1);

        // 6: error response, then reset while in ISSUE
        aw0 = aw_cnt;
        expect_wr(21'h00002, 16'h0567);
        expect_wr(21'h00004, 16'h089A);
        send_pix(1, 0, 5, 6, 7, 1'b0);
        send_pix(2, 0, 8, 9, 10, 1'b0);
        repeat (2) tick();
        send_b(2'b00);
        check("t6_err_clear", axi_error, 0);
        send_b(2'b10);
        check("t6_err_set", axi_error, 1);
        expect_wr(21'h00006, 16'h0BCD);
        send_pix(3, 0, 11, 12, 13, 1'b0);
        repeat (2) tick();
        check("t6_write_continues", aw_cnt - aw0, 3);
        send_b(2'b00);
        check("t6_err_sticky", axi_error, 1);

        m_axi_awready = 1'b0;
        send_pix(4, 0, 1, 1, 1, 1'b0);
        check("t6_issue_awvalid", m_axi_awvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_awvalid", m_axi_awvalid, 0);
        check("t6_rst_wvalid", m_axi_wvalid, 0);
        check("t6_rst_ready", s_pix_ready, 0);
        tick();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_error", axi_error, 0);
        check("t6_rst_fd", frame_done, 0);
        rst_n = 1'b1;
        m_axi_awready = 1'b1;
        tick();
        check("t6_post_awvalid", m_axi_awvalid, 0);
        check("t6_post_wvalid", m_axi_wvalid, 0);
        check("t6_post_ready", s_pix_ready, 1);
        check("t6_post_busy", busy, 0);
        check("t6_post_bready", m_axi_bready, 1);
        check("sb_aw_drained", exp_q.size(), 0);
        check("sb_w_drained", expd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gfx_pixel_axi_writer.md
Name: gfx_pixel_axi_writer

Overview:
- Pixel-write stage directly upstream of the SRAM AXI slave in the gfx pattern path.
- Consumes a valid/ready stream of (x, y, RGB) pixels from a pattern generator.
- Converts each in-range pixel into a single-beat AXI4 write to the linear framebuffer.
- Tracks outstanding write responses, signals frame completion, and reports bus errors.

Parameters:
- AXI_ADDR_WIDTH, 21: AXI byte-address width.
- AXI_DATA_WIDTH, 16: AXI data width. Must be ≥ 3*COLOR_WIDTH and a power of two ≥ 8.
- AXI_ID_WIDTH, 4: AXI ID width.
- COLOR_WIDTH, 4: bits per colour channel.
- H_WIDTH, 12: x coordinate width.
- V_WIDTH, 12: y coordinate width.
- FB_WIDTH, 640: framebuffer pixels per line.
- FB_HEIGHT, 480: framebuffer lines.
- MAX_OUTSTANDING, 4: maximum AW handshakes awaiting a B response.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- s_pix_valid  in  1  pixel valid.
- s_pix_ready  out  1  pixel ready.
- s_pix_x  in  H_WIDTH  pixel column.
- s_pix_y  in  V_WIDTH  pixel line.
- s_pix_red / s_pix_grn / s_pix_blu  in  COLOR_WIDTH each  pixel colour.
- s_pix_last  in  1  last pixel of frame.
- m_axi_awvalid / awready / awaddr / awid / awlen / awsize / awburst: AXI write-address channel (out except awready).
- m_axi_wvalid / wready / wdata / wstrb / wlast: AXI write-data channel (out except wready).
- m_axi_bvalid / bid / bresp  in; m_axi_bready  out: AXI write-response channel.
- frame_done  out  1  one-cycle pulse when a frame's writes have all completed.
- busy  out  1  pixel held or any response outstanding.
- axi_error  out  1  sticky flag: a non-OKAY bresp was received.

Behaviour:
- Reset (rst_n low at a clk edge): awvalid=0, wvalid=0, s_pix_ready=0 for that cycle; bready=1; frame_done=0; busy=0; axi_error=0; outstanding count=0; pending_last=0; FSM=IDLE.
  - Reset mid-transaction abandons any held pixel and the outstanding count; no AXI handshakes complete while reset is asserted.
- Constant AXI fields: awlen=0, awsize=$clog2(AXI_DATA_WIDTH/8), awburst=INCR (2'b01), awid=0, wstrb=all ones, wlast=1, bready=1 outside reset.
- Address: awaddr = (y*FB_WIDTH + x) << $clog2(AXI_DATA_WIDTH/8), truncated to AXI_ADDR_WIDTH. Computed from registered x/y and held stable while awvalid is high.
- Data: wdata = {zero-pad, red, grn, blu}, with blu in the LSBs.
- FSM:
  - IDLE:
    - s_pix_ready = (outstanding < MAX_OUTSTANDING).
    - On s_pix_valid & s_pix_ready: capture x, y, colour and last.
    - If x ≥ FB_WIDTH or y ≥ FB_HEIGHT: drop the pixel (no AXI traffic), stay in IDLE, still honour last.
    - Otherwise go to ISSUE.
  - ISSUE:
    - awvalid and wvalid are both asserted from the cycle after capture (1-cycle latency). s_pix_ready=0.
    - Each valid deasserts independently the cycle after its own handshake.
    - When both have been accepted (same cycle or different cycles), return to IDLE. s_pix_ready may reassert the next cycle, so throughput is at most 1 pixel per 2 cycles.
- Outstanding counter:
  - +1 on AW handshake, −1 on B handshake.
  - Both in the same cycle: count unchanged.
  - Never exceeds MAX_OUTSTANDING, because a pixel is only accepted while count < MAX_OUTSTANDING.
- Frame completion:
  - Capturing last sets pending_last. This applies to dropped pixels too.
  - frame_done pulses for exactly one cycle when pending_last=1, FSM=IDLE and outstanding=0; pending_last clears in that same cycle.
  - A dropped last pixel with nothing outstanding gives frame_done the cycle after capture.
- Errors: axi_error sets on bvalid with bresp≠2'b00 and clears only on reset. Writing continues after an error.
- busy = (FSM≠IDLE) | (outstanding≠0).

Decomposition:
- gfx_pkg: AXI_BURST_INCR, AXI_RESP_OKAY constants; writer FSM state enum (IDLE, ISSUE).
- No sub-module required. Address multiply is a constant multiply kept inline.

Test Plan:
1. FB_WIDTH=640, 16-bit data; pixel x=3, y=2, rgb=A/5/C with awready=wready=1 → one cycle later awaddr=0xA06, wdata=0x0A5C, awlen=0, awsize=1, awburst=01, wstrb=11, wlast=1; both valids low the following cycle.
2. Backpressure: awready held low 5 cycles, wready=1 → W accepted first; awvalid holds with a stable address until AW is accepted; s_pix_ready stays 0 throughout; exactly one AW and one W handshake.
3. MAX_OUTSTANDING=4, bvalid withheld, continuous pixels → exactly 4 AW handshakes, then s_pix_ready=0; one B accepted → s_pix_ready=1 the next cycle.
4. 4-pixel frame with last on the 4th, responses delayed → frame_done pulses once, only after the 4th B; busy falls in the same cycle.
5. Pixel x=640, y=0 with last, nothing outstanding → no AXI activity; frame_done pulses the cycle after capture.
6. bresp=2'b10 on the 2nd response → axi_error=1 and stays set; subsequent writes continue. Assert rst_n=0 while a pixel is held in ISSUE → outputs return to reset values and axi_error=0.
